ysyx_24100006_pipe_ctrl: RTL and testbench
==========================================

// Module: ysyx_24100006_pipe_ctrl
// PURPOSE
//  Central flush/stall/redirect scheduler for the IF->IF_ID->ID_EX front end.
//  - Arbitrates redirect sources: WB trap/mret, EX branch mispredict, fence.i.
//  - Drives flush_i of the pipeline registers and the PC redirect to IFU.
//  - Detects load-use hazards and sequences fence.i: drain LSU, flush I-cache, restart.
// PARAMETERS
//  ADDR_W  32  PC / redirect address width
//  RIDX_W  4   register index width (RV32E)
// PORTS
//  clock            in   1       clock, all state on rising edge
//  reset            in   1       synchronous, active-high
//  wb_trap_valid    in   1       WB trap/mret redirect request (oldest)
//  wb_trap_pc       in   ADDR_W  trap/mret target
//  ex_br_valid      in   1       EX branch/jump mispredict request
//  ex_br_pc         in   ADDR_W  branch target
//  ex_fencei        in   1       fence.i in EX, valid this cycle
//  ex_pc_add_4      in   ADDR_W  pc+4 of the fence.i
//  lsu_idle         in   1       no outstanding store/load in LSU/MEM/WB
//  ic_flush_done    in   1       I-cache invalidate done (1-cycle pulse)
//  id_valid         in   1       IF_ID out_valid
//  id_rs1, id_rs2   in   RIDX_W  source regs of the instruction in ID
//  ex_valid         in   1       ID_EX out_valid
//  ex_is_load       in   1       instruction in EX is a load
//  ex_rd            in   RIDX_W  destination of the instruction in EX
//  flush_if_id      out  1       to IF_ID flush_i
//  flush_id_ex      out  1       to ID_EX flush_i
//  redirect_valid   out  1       IFU loads redirect_pc this cycle
//  redirect_pc      out  ADDR_W  new fetch address
//  hold_id          out  1       forces IF_ID out_ready low (stall ID)
//  bubble_ex        out  1       ID_EX accepts an invalid entry
//  fetch_stall      out  1       IFU issues no new fetch
//  ic_flush_req     out  1       level request to I-cache invalidate
// BEHAVIOUR
//  - FSM states: IDLE, DRAIN, ICFLUSH, RESTART. Reset -> IDLE.
//  - Outputs 0 during reset; redirect_pc 0 when redirect_valid=0.
//  - Redirects are combinational (same-cycle) from the inputs.
//  - IDLE redirect priority: wb_trap_valid > ex_br_valid > ex_fencei.
//  - Trap: redirect_valid=1, redirect_pc=wb_trap_pc, flush_if_id=flush_id_ex=1.
//  - Branch (no trap): same, with ex_br_pc.
//  - fence.i (no trap/branch):
//    - flush_if_id=flush_id_ex=1; ex_pc_add_4 latched into ret_pc.
//    - Next state DRAIN; no redirect in this cycle.
//  - DRAIN:
//    - fetch_stall=1; waits for lsu_idle=1, then ICFLUSH.
//    - lsu_idle already 1 on entry: still spends exactly one cycle in DRAIN.
//    - wb_trap_valid in DRAIN aborts the fence: trap redirect+flush, -> IDLE, ret_pc discarded.
//  - ICFLUSH:
//    - fetch_stall=1, ic_flush_req=1 held until ic_flush_done, then RESTART.
//    - The trap cannot occur here (pipe empty). Bench asserts wb_trap_valid=0.
//  - RESTART (one cycle): redirect_valid=1, redirect_pc=ret_pc, fetch_stall=1, -> IDLE.
//  - Load-use hazard (IDLE only):
//    - Condition: id_valid & ex_valid & ex_is_load & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
//    - Drives hold_id=1, bubble_ex=1.
//    - Suppressed when any redirect/flush is asserted that cycle (flush wins).
//  - fetch_stall=0 in IDLE; hold_id=bubble_ex=0 in non-IDLE states.
//  - ex_br_valid/ex_fencei are ignored outside IDLE; the pipe is flushed there.
//  - Reset mid-sequence: -> IDLE immediately, ic_flush_req drops the same edge.
// TESTING
//  - Reset hold 3 cycles, release -> all outputs 0, state IDLE.
//  - ex_br_valid=1, ex_br_pc=0x8000_0040 -> same cycle redirect_valid=1, pc=0x8000_0040, both flushes=1.
//  - Priority: trap(0x8000_0100)+branch(0x8000_0040) together -> redirect_pc=0x8000_0100, one redirect only.
//  - fence.i at pc+4=0x8000_0024:
//    - lsu_idle=0 for 3 cycles -> DRAIN held, ic_flush_req=0.
//    - lsu_idle=1 -> ICFLUSH with ic_flush_req=1.
//    - done pulse after 5 cycles -> 1-cycle redirect to 0x8000_0024.
//  - Load-use, ex_rd=5=id_rs2, ex_is_load=1 -> hold_id=bubble_ex=1 for that cycle.
//    - Same with ex_rd=0 -> no stall.
//    - Same with ex_br_valid=1 -> flush only, no stall.
//  - Trap during DRAIN -> redirect to trap pc, IDLE, no later RESTART.
//    - Reset asserted in ICFLUSH -> ic_flush_req=0 next cycle.

Source files
------------

// File: rtl/ysyx_24100006_pipe_ctrl.sv
// Front-end flush/stall/redirect scheduler: arbitrates trap, branch and fence.i
// redirects, sequences the fence.i drain/I-cache-invalidate, and detects load-use stalls.
module ysyx_24100006_pipe_ctrl #(
    parameter int ADDR_W = 32,
    parameter int RIDX_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_trap_valid,
    input  logic [ADDR_W-1:0] wb_trap_pc,
    input  logic              ex_br_valid,
    input  logic [ADDR_W-1:0] ex_br_pc,
    input  logic              ex_fencei,
    input  logic [ADDR_W-1:0] ex_pc_add_4,
    input  logic              lsu_idle,
    input  logic              ic_flush_done,
    input  logic              id_valid,
    input  logic [RIDX_W-1:0] id_rs1,
    input  logic [RIDX_W-1:0] id_rs2,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [RIDX_W-1:0] ex_rd,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              hold_id,
    output logic              bubble_ex,
    output logic              fetch_stall,
    output logic              ic_flush_req
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_ICFLUSH = 2'd2;
    localparam logic [1:0] S_RESTART = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
    logic              load_use;

    assign load_use = id_valid & ex_valid & ex_is_load & (ex_rd != '0) &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // Every output is gated by reset so the pipeline sees a quiet scheduler while held.
    always_comb begin
        state_d        = state_q;
        ret_pc_d       = ret_pc_q;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        hold_id        = 1'b0;
        bubble_ex      = 1'b0;
        fetch_stall    = 1'b0;
        ic_flush_req   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (wb_trap_valid) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = wb_trap_pc;
                        flush_if_id    = 1'b1;
                        flush_id_ex    = 1'b1;
                    end else if (ex_br_valid) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = ex_br_pc;
                        flush_if_id    = 1'b1;
                        flush_id_ex    = 1'b1;
                    end else if (ex_fencei) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        ret_pc_d    = ex_pc_add_4;
                        state_d     = S_DRAIN;
                    end else if (load_use) begin
                        hold_id   = 1'b1;
                        bubble_ex = 1'b1;
                    end
                end
                S_DRAIN: begin
                    fetch_stall = 1'b1;
                    // An older trap reaching WB abandons the fence; its return pc is dropped.
                    if (wb_trap_valid) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = wb_trap_pc;
                        flush_if_id    = 1'b1;
                        flush_id_ex    = 1'b1;
                        state_d        = S_IDLE;
                    end else if (lsu_idle) begin
                        state_d = S_ICFLUSH;
                    end
                end
                S_ICFLUSH: begin
                    fetch_stall  = 1'b1;
                    ic_flush_req = 1'b1;
                    if (ic_flush_done) begin
                        state_d = S_RESTART;
                    end
                end
                default: begin
                    redirect_valid = 1'b1;
                    redirect_pc    = ret_pc_q;
                    fetch_stall    = 1'b1;
                    state_d        = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
        ret_pc_q <= ret_pc_d;
    end

endmodule

// File: tb/tb_ysyx_24100006_pipe_ctrl.sv
// Bench for ysyx_24100006_pipe_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural fence/redirect model.
module tb_ysyx_24100006_pipe_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_trap_valid, ex_br_valid, ex_fencei, lsu_idle, ic_flush_done;
    logic [31:0] wb_trap_pc, ex_br_pc, ex_pc_add_4;
    logic        id_valid, ex_valid, ex_is_load;
    logic [3:0]  id_rs1, id_rs2, ex_rd;
    logic        flush_if_id, flush_id_ex, redirect_valid, hold_id, bubble_ex;
    logic        fetch_stall, ic_flush_req;
    logic [31:0] redirect_pc;

    int checks = 0;
    int failures = 0;

    ysyx_24100006_pipe_ctrl #(.ADDR_W(32), .RIDX_W(4)) dut (
        .clock(clock), .reset(reset),
        .wb_trap_valid(wb_trap_valid), .wb_trap_pc(wb_trap_pc),
        .ex_br_valid(ex_br_valid), .ex_br_pc(ex_br_pc),
        .ex_fencei(ex_fencei), .ex_pc_add_4(ex_pc_add_4),
        .lsu_idle(lsu_idle), .ic_flush_done(ic_flush_done),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .hold_id(hold_id), .bubble_ex(bubble_ex),
        .fetch_stall(fetch_stall), .ic_flush_req(ic_flush_req)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a fence in flight is described by what has been achieved so far.
    bit          m_fence, m_drained, m_cached;
    logic [31:0] m_ret;
    logic        e_fid, e_fex, e_rv, e_hold, e_bub, e_stall, e_req;
    logic [31:0] e_pc;

    always @(negedge clock) begin
        {e_fid, e_fex, e_rv, e_hold, e_bub, e_stall, e_req} = '0;
        e_pc = 32'h0;
        if (reset) begin
            m_fence = 1'b0;
        end else if (!m_fence) begin
            if (wb_trap_valid) begin
                {e_rv, e_fid, e_fex} = 3'b111;
                e_pc = wb_trap_pc;
            end else if (ex_br_valid) begin
                {e_rv, e_fid, e_fex} = 3'b111;
                e_pc = ex_br_pc;
            end else if (ex_fencei) begin
                {e_fid, e_fex} = 2'b11;
                m_fence = 1'b1; m_drained = 1'b0; m_cached = 1'b0;
                m_ret = ex_pc_add_4;
            end else if (id_valid && ex_valid && ex_is_load && ex_rd != 0 &&
                         (ex_rd == id_rs1 || ex_rd == id_rs2)) begin
                {e_hold, e_bub} = 2'b11;
            end
        end else if (!m_drained) begin
            e_stall = 1'b1;
            if (wb_trap_valid) begin
                {e_rv, e_fid, e_fex} = 3'b111;
                e_pc = wb_trap_pc;
                m_fence = 1'b0;
            end else if (lsu_idle) begin
                m_drained = 1'b1;
            end
        end else if (!m_cached) begin
            {e_stall, e_req} = 2'b11;
            if (ic_flush_done) m_cached = 1'b1;
        end else begin
            {e_rv, e_stall} = 2'b11;
            e_pc = m_ret;
            m_fence = 1'b0;
        end
        chk("flush_if_id", {31'b0, flush_if_id}, {31'b0, e_fid});
        chk("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, e_fex});
        chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, e_rv});
        chk("redirect_pc", redirect_pc, e_pc);
        chk("hold_id", {31'b0, hold_id}, {31'b0, e_hold});
        chk("bubble_ex", {31'b0, bubble_ex}, {31'b0, e_bub});
        chk("fetch_stall", {31'b0, fetch_stall}, {31'b0, e_stall});
        chk("ic_flush_req", {31'b0, ic_flush_req}, {31'b0, e_req});
    end

    task automatic quiet();
        wb_trap_valid = 0; ex_br_valid = 0; ex_fencei = 0; lsu_idle = 1; ic_flush_done = 0;
        wb_trap_pc = 32'h0; ex_br_pc = 32'h0; ex_pc_add_4 = 32'h0;
        id_valid = 0; ex_valid = 0; ex_is_load = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        quiet();
    endtask

    initial begin
        reset = 1'b1;
        quiet();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("post_reset_outputs",
            {24'b0, flush_if_id, flush_id_ex, redirect_valid, hold_id, bubble_ex,
             fetch_stall, ic_flush_req, 1'b0}, 32'h0);
        chk("post_reset_pc", redirect_pc, 32'h0);

        tick(); ex_br_valid = 1; ex_br_pc = 32'h8000_0040; #1;
        chk("br_rv", {31'b0, redirect_valid}, 32'd1);
        chk("br_pc", redirect_pc, 32'h8000_0040);
        chk("br_flush", {30'b0, flush_if_id, flush_id_ex}, 32'd3);

        tick(); ex_br_valid = 1; ex_br_pc = 32'h8000_0040;
        wb_trap_valid = 1; wb_trap_pc = 32'h8000_0100; #1;
        chk("prio_pc", redirect_pc, 32'h8000_0100);

        tick(); ex_fencei = 1; ex_pc_add_4 = 32'h8000_0024; lsu_idle = 0; #1;
        chk("fence_flush", {30'b0, flush_if_id, flush_id_ex}, 32'd3);
        chk("fence_no_redirect", {31'b0, redirect_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); lsu_idle = 0; #1;
            chk("drain_stall", {31'b0, fetch_stall}, 32'd1);
            chk("drain_no_req", {31'b0, ic_flush_req}, 32'd0);
        end
        tick(); lsu_idle = 1; #1;
        chk("drain_exit_no_req", {31'b0, ic_flush_req}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk("icflush_req", {31'b0, ic_flush_req}, 32'd1);
        end
        tick(); ic_flush_done = 1; #1;
        chk("icflush_done_req", {31'b0, ic_flush_req}, 32'd1);
        tick(); #1;
        chk("restart_rv", {31'b0, redirect_valid}, 32'd1);
        chk("restart_pc", redirect_pc, 32'h8000_0024);
        tick(); #1;
        chk("restart_once", {31'b0, redirect_valid}, 32'd0);

        tick(); id_valid = 1; ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_rs1 = 3; id_rs2 = 5; #1;
        chk("loaduse_stall", {30'b0, hold_id, bubble_ex}, 32'd3);
        tick(); id_valid = 1; ex_valid = 1; ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; #1;
        chk("loaduse_x0", {30'b0, hold_id, bubble_ex}, 32'd0);
        tick(); id_valid = 1; ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_rs2 = 5;
        ex_br_valid = 1; ex_br_pc = 32'h8000_0080; #1;
        chk("loaduse_flush_wins", {29'b0, hold_id, bubble_ex, flush_if_id}, 32'd1);

        tick(); ex_fencei = 1; ex_pc_add_4 = 32'h8000_0200; lsu_idle = 0; #1;
        tick(); wb_trap_valid = 1; wb_trap_pc = 32'h8000_0300; lsu_idle = 0; #1;
        chk("drain_trap_pc", redirect_pc, 32'h8000_0300);
        chk("drain_trap_flush", {30'b0, flush_if_id, flush_id_ex}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("no_late_restart", {30'b0, redirect_valid, fetch_stall}, 32'd0);
        end

        tick(); ex_fencei = 1; ex_pc_add_4 = 32'h8000_0400; #1;
        tick(); #1;
        tick(); #1;
        chk("in_icflush", {31'b0, ic_flush_req}, 32'd1);
        tick(); reset = 1; #1;
        tick(); #1;
        reset = 0; #1;
        chk("reset_drops_req", {31'b0, ic_flush_req}, 32'd0);
        chk("reset_idle_stall", {31'b0, fetch_stall}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            @(posedge clock);
            #1;
            reset         = ($urandom_range(0, 99) == 0);
            wb_trap_valid = ($urandom_range(0, 7) == 0);
            ex_br_valid   = ($urandom_range(0, 5) == 0);
            ex_fencei     = ($urandom_range(0, 5) == 0);
            lsu_idle      = $urandom_range(0, 1);
            wb_trap_pc    = $urandom;
            ex_br_pc      = $urandom;
            ex_pc_add_4   = $urandom;
            id_valid      = $urandom_range(0, 1);
            ex_valid      = $urandom_range(0, 1);
            ex_is_load    = $urandom_range(0, 1);
            id_rs1        = 4'($urandom_range(0, 3));
            id_rs2        = 4'($urandom_range(0, 3));
            ex_rd         = 4'($urandom_range(0, 3));
            ic_flush_done = 1'b0;
            if (m_fence && m_drained && !m_cached) begin
                wb_trap_valid = 1'b0;
                ic_flush_done = ($urandom_range(0, 3) == 0);
            end
        end
        @(posedge clock);
        #1 quiet();
        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
